// File: rtl/hdlc_bit_stuff_transmitter.sv
// hdlc_bit_stuff_transmitter: HDLC-style framer that wraps words in 01111110 flags, sends LSB first and stuffs a 0 after five data ones.
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   data_in_i     payload word, sent LSB first
//   data_valid_i  data_in_i / data_last_i are valid
//   data_last_i   word closes its frame
//   data_ready_o  holding buffer empty (registered); word transfers on valid & ready
//   serial_out_o  registered serial line, idles at 0
//   tx_active_o   high while an opening flag, payload or closing flag is on the line
//   underrun_o    one-cycle pulse in the first closing-flag cycle of a frame cut short
module hdlc_bit_stuff_transmitter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  data_valid_i,
    input  logic                  data_last_i,
    output logic                  data_ready_o,
    output logic                  serial_out_o,
    output logic                  tx_active_o,
    output logic                  underrun_o
);
    localparam int CW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;
    localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] FLAG_LAST = CW'(7);
    // Flag sent LSB first gives 0,1,1,1,1,1,1,0 on the line.
    localparam logic [7:0] FLAG = 8'h7E;

    typedef enum logic [1:0] {IDLE, OPEN_FLAG, DATA, CLOSE_FLAG} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            ones_q, ones_d, ones_inc;
    logic                  stuff_q, stuff_d;
    logic                  stuff_end_q, stuff_end_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, buf_q, buf_d;
    logic                  last_q, last_d, buf_last_q, buf_last_d, buf_full_q, buf_full_d;
    logic                  ready_q, ready_d, serial_q, serial_d, active_q, active_d;
    logic                  underrun_q, underrun_d;
    logic                  accept, load, word_end;

    assign accept = data_valid_i && ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        stuff_d     = stuff_q;
        stuff_end_d = stuff_end_q;
        shift_d     = shift_q;
        last_d      = last_q;
        underrun_d  = 1'b0;
        load        = 1'b0;
        word_end    = 1'b0;
        ones_inc    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (buf_full_q) state_d = OPEN_FLAG;
            end
            OPEN_FLAG: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == FLAG_LAST) begin
                    state_d = DATA;
                    load    = 1'b1;
                    ones_d  = '0;
                    stuff_d = 1'b0;
                end
            end
            DATA: begin
                if (stuff_q) begin
                    // Stuffed 0 on the line: hold the shift register.
                    ones_d   = '0;
                    stuff_d  = 1'b0;
                    word_end = stuff_end_q;
                end else begin
                    ones_d      = ones_inc;
                    shift_d     = shift_q >> 1;
                    cnt_d       = (cnt_q == WORD_LAST) ? '0 : cnt_q + CW'(1);
                    stuff_d     = ones_inc == 3'd5;
                    // Remember whether the pending stuff closes the word.
                    stuff_end_d = cnt_q == WORD_LAST;
                    word_end    = cnt_q == WORD_LAST && ones_inc != 3'd5;
                end
            end
            CLOSE_FLAG: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == FLAG_LAST) begin
                    state_d = buf_full_q ? OPEN_FLAG : IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        if (word_end) begin
            if (last_q || !buf_full_q) begin
                state_d    = CLOSE_FLAG;
                cnt_d      = '0;
                underrun_d = !last_q;
            end else begin
                load = 1'b1;
            end
        end
        if (load) begin
            shift_d = buf_q;
            last_d  = buf_last_q;
            cnt_d   = '0;
        end
    end

    assign buf_d      = accept ? data_in_i : buf_q;
    assign buf_last_d = accept ? data_last_i : buf_last_q;
    assign buf_full_d = accept || (buf_full_q && !load);
    // Ready lags a drain by one cycle, and drops at once on accept.
    assign ready_d    = !buf_full_d && !buf_full_q;
    assign active_d   = state_d != IDLE;
    // The line is registered from next-state values so it lines up with the state it describes.
    assign serial_d   = (state_d == DATA) ? (!stuff_d && shift_d[0]) :
                        (state_d == IDLE) ? 1'b0 : FLAG[cnt_d[2:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ones_q      <= '0;
            stuff_q     <= 1'b0;
            stuff_end_q <= 1'b0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            buf_q       <= '0;
            buf_last_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            ready_q     <= 1'b1;
            serial_q    <= 1'b0;
            active_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            stuff_q     <= stuff_d;
            stuff_end_q <= stuff_end_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            buf_q       <= buf_d;
            buf_last_q  <= buf_last_d;
            buf_full_q  <= buf_full_d;
            ready_q     <= ready_d;
            serial_q    <= serial_d;
            active_q    <= active_d;
            underrun_q  <= underrun_d;
        end
    end

    assign data_ready_o = ready_q;
    assign serial_out_o = serial_q;
    assign tx_active_o  = active_q;
    assign underrun_o   = underrun_q;
endmodule

// File: tb/tb_hdlc_bit_stuff_transmitter.sv
// tb_hdlc_bit_stuff_transmitter: directed and randomized self-checking bench for the HDLC bit-stuffing transmitter.
module tb_hdlc_bit_stuff_transmitter;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] data_in_i = '0;
    logic       data_valid_i = 1'b0;
    logic       data_last_i = 1'b0;
    logic       data_ready_o, serial_out_o, tx_active_o, underrun_o;

    hdlc_bit_stuff_transmitter #(.DATA_WIDTH(8)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .data_in_i(data_in_i),
        .data_valid_i(data_valid_i),
        .data_last_i(data_last_i),
        .data_ready_o(data_ready_o),
        .serial_out_o(serial_out_o),
        .tx_active_o(tx_active_o),
        .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] s2v(input string s);
        logic [63:0] v = '0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != " ") v = {v[62:0], s[i] == "1"};
        return v;
    endfunction

    // Reference: accepted words in order, and a destuffer that rebuilds frames from the line.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } word_t;

    word_t acc[$];
    logic  seg[$];
    bit    mon_en = 0, tail = 0, b2b_exp = 0, seen_close = 0;
    int    run = 0, flags = 0, urun = 0, cyc = 0, close_cyc = 0, bytes_rx = 0, sent = 0;

    always @(posedge clk_i)
        if (mon_en && data_valid_i && data_ready_o) acc.push_back('{data_in_i, data_last_i});

    task automatic close_frame();
        int nb = seg.size() / 8;
        check("frame_bits", 64'(seg.size() % 8), 0);
        check("frame_nonempty", nb > 0, 1);
        for (int i = 0; i < nb; i++) begin
            logic [7:0] b = '0;
            for (int j = 0; j < 8; j++) b[j] = seg[i*8+j];
            bytes_rx++;
            check("word_avail", acc.size() != 0, 1);
            if (acc.size() != 0) begin
                word_t w = acc.pop_front();
                check("byte", b, w.d);
                if (i == nb - 1) check("underrun", 64'(urun), w.l ? 0 : 1);
                else check("last_pos", w.l, 0);
            end
        end
        close_cyc = cyc;
        seen_close = 1;
    endtask

    always @(negedge clk_i) if (mon_en) begin
        cyc++;
        if (underrun_o) urun++;
        if (tail) begin
            tail = 0;
            check("flag_tail", serial_out_o, 0);
            if (flags % 2 == 0) b2b_exp = acc.size() != 0;
            seg.delete();
            run = 0;
        end else if (serial_out_o) begin
            run++;
            if (run == 6) begin
                tail = 1;
                repeat (6) if (seg.size() != 0) void'(seg.pop_back());
                if (flags % 2 == 0) begin
                    if (seen_close) begin
                        if (b2b_exp) check("b2b_gap", 64'(cyc - close_cyc), 8);
                        else check("idle_gap", cyc - close_cyc > 8, 1);
                    end
                    urun = 0;
                end else begin
                    close_frame();
                end
                flags++;
            end else begin
                seg.push_back(1'b1);
            end
        end else begin
            if (run != 5) seg.push_back(1'b0);
            run = 0;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int w = 0;
        data_in_i = d;
        data_last_i = l;
        data_valid_i = 1'b1;
        while (!data_ready_o && w < 500) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 500) check("ready_timeout", data_ready_o, 1);
        @(negedge clk_i);
        data_valid_i = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] bits, output int act, output int upos, output int ucnt);
        int w = 0;
        bits = '0;
        act = 0;
        upos = -1;
        ucnt = 0;
        while (!tx_active_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check("tx_start", tx_active_o, 1);
        for (int i = 0; i < n; i++) begin
            bits = {bits[62:0], serial_out_o};
            act += int'(tx_active_o);
            if (underrun_o) begin
                ucnt++;
                upos = i;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic frame_test(input string tag, input string exp, input int n, input int exp_upos);
        logic [63:0] bits;
        int act, upos, ucnt;
        capture(n, bits, act, upos, ucnt);
        check({tag, "_bits"}, bits, s2v(exp));
        check({tag, "_active"}, 64'(act), 64'(n));
        check({tag, "_underrun_cnt"}, 64'(ucnt), exp_upos < 0 ? 0 : 1);
        check({tag, "_underrun_pos"}, 64'(upos), 64'(exp_upos));
        check({tag, "_idle_line"}, serial_out_o, 0);
        check({tag, "_idle_active"}, tx_active_o, 0);
        check({tag, "_ready"}, data_ready_o, 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_serial", serial_out_o, 0);
        check("rst_ready", data_ready_o, 1);
        check("rst_active", tx_active_o, 0);
        check("rst_underrun", underrun_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        send(8'hFF, 1'b1);
        repeat (12) @(negedge clk_i);
        check("pre_rst_active", tx_active_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_serial", serial_out_o, 0);
        check("async_rst_active", tx_active_o, 0);
        check("async_rst_underrun", underrun_o, 0);
        check("async_rst_ready", data_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        begin
            int ones;
            ones = 0;
            repeat (20) begin
                @(negedge clk_i);
                ones += int'(serial_out_o) + int'(tx_active_o);
            end
            check("post_rst_quiet", 64'(ones), 0);
        end

        fork
            send(8'h00, 1'b1);
            frame_test("zero", "01111110 00000000 01111110", 24, -1);
        join
        fork
            send(8'hFF, 1'b1);
            frame_test("ff", "01111110 111110111 01111110", 25, -1);
        join
        fork
            begin
                send(8'hF0, 1'b0);
                send(8'h0F, 1'b1);
            end
            frame_test("cross", "01111110 00001111 101110000 01111110", 33, -1);
        join
        fork
            send(8'h55, 1'b0);
            frame_test("urun", "01111110 10101010 01111110", 24, 16);
        join
        repeat (5) @(negedge clk_i);

        mon_en = 1;
        for (int f = 0; f < 200; f++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                int gap;
                logic [7:0] d;
                gap = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 30) : $urandom_range(0, 2);
                d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                repeat (gap) @(negedge clk_i);
                send(d, k == nw - 1);
                sent++;
            end
            repeat ($urandom_range(0, 6)) @(negedge clk_i);
        end
        begin
            int w;
            w = 0;
            while ((acc.size() != 0 || tx_active_o || tail) && w < 3000) begin
                @(negedge clk_i);
                w++;
            end
            check("drain", w < 3000, 1);
        end
        @(negedge clk_i);
        check("bytes_total", 64'(bytes_rx), 64'(sent));
        check("flag_parity", 64'(flags % 2), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
